// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle for the UART receiver.
// master is the receiver side, slave is the line driver plus byte consumer.
interface uart_rx_if #(
  parameter int NB_DATA_OUT = 8
);
  logic                   i_data;
  logic [NB_DATA_OUT-1:0] o_data;
  logic                   o_valid;
  logic                   o_frame_err;
  logic                   o_busy;

  modport master (
    input  i_data,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    output i_data,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: validates the start bit at mid-bit, samples each data bit
// one bit period later, and pulses o_valid or o_frame_err after the stop sample.
module uart_rx #(
  parameter int BAUD_RATE    = 115200,
  parameter int CLOCK_FREQ   = 10000000,
  parameter int CLKS_PER_BIT = 87,
  parameter int NB_DATA_OUT  = 8
) (
  input logic       clock,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam logic [7:0] HALF      = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);
  localparam int         IDX_W     = (NB_DATA_OUT > 1) ? $clog2(NB_DATA_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_DATA_OUT - 1);

  // The 8-bit counter cannot time a bit longer than 255 clocks.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 255) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be within 4..255");
  end
  if (CLOCK_FREQ < 4 * BAUD_RATE) begin : g_bad_rate
    $error("uart_rx: CLOCK_FREQ too low for BAUD_RATE");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [7:0]             counter;
  logic [IDX_W-1:0]       bit_idx;
  logic [NB_DATA_OUT-1:0] shift_reg;
  logic [NB_DATA_OUT-1:0] data_q;
  logic                   valid_q;
  logic                   frame_err_q;

  // Both flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_data;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            counter <= '0;
          end
        end
        START: begin
          if (counter == HALF) begin
            counter <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        DATA: begin
          if (counter == LAST_TICK) begin
            counter            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            counter <= counter + 8'd1;
          end
        end
        STOP: begin
          // Leaving mid stop bit lets a start bit that follows immediately be caught.
          if (counter == LAST_TICK) begin
            counter <= '0;
            if (rx_s) begin
              data_q  <= shift_reg;
              valid_q <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            counter <= counter + 8'd1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state   <= IDLE;
            counter <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level timing model predicts every output per cycle,
// directed scenarios pin exact latencies and bytes, then random frames follow.
module tb_uart_rx;

  localparam int CPB  = 87;
  localparam int NB   = 8;
  localparam int HALF = (CPB - 1) / 2;
  // Edges from the first low sample of a start bit to the visible result pulse.
  localparam int PULSE_LAT = HALF + (NB + 1) * CPB + 3;

  logic clock;
  logic reset;
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   chk_en = 1'b0;

  bit         exp_valid[int];
  bit         exp_ferr[int];
  bit         exp_busy[int];
  logic [7:0] exp_data_chg[int];
  logic [7:0] cur_data = 8'h00;

  int vtimes[$];
  int vdatas[$];
  int ftimes[$];

  uart_rx_if #(.NB_DATA_OUT(NB)) bus ();

  uart_rx #(
    .BAUD_RATE   (115200),
    .CLOCK_FREQ  (10000000),
    .CLKS_PER_BIT(CPB),
    .NB_DATA_OUT (NB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  // Per-cycle comparison against the frame-level model.
  always @(posedge clock) begin
    bit e_v, e_f, e_b;
    #1;
    if (exp_data_chg.exists(edge_n)) cur_data = exp_data_chg[edge_n];
    if (chk_en) begin
      e_v = exp_valid.exists(edge_n);
      e_f = exp_ferr.exists(edge_n);
      e_b = exp_busy.exists(edge_n);
      n_cmp++;
      if (bus.o_valid !== e_v || bus.o_frame_err !== e_f ||
          bus.o_busy !== e_b || bus.o_data !== cur_data) begin
        n_bad++;
        $display("[TB] FAIL cycle_check @%0d: got valid=%b ferr=%b busy=%b data=%h, want valid=%b ferr=%b busy=%b data=%h",
                 edge_n, bus.o_valid, bus.o_frame_err, bus.o_busy, bus.o_data, e_v, e_f, e_b, cur_data);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (bus.o_valid === 1'b1) begin
      vtimes.push_back(edge_n);
      vdatas.push_back(int'(bus.o_data));
    end
    if (bus.o_frame_err === 1'b1) ftimes.push_back(edge_n);
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic clear_log();
    vtimes.delete();
    vdatas.delete();
    ftimes.delete();
  endtask

  task automatic idle(input int n);
    bus.i_data = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Drives start, data LSB first, stop; cells alternate +j/-j to model edge jitter.
  task automatic send_frame(input logic [7:0] b, input bit good, input int jit_lo,
                            input int jit_hi, input int extra_low, output int f);
    int p, h, j;
    int lens[10];
    logic [9:0] cells;
    f     = edge_n + 1;
    p     = f + PULSE_LAT;
    cells = {good, b, 1'b0};
    for (int m = 0; m < 5; m++) begin
      j               = int'($urandom_range(jit_hi, jit_lo));
      lens[2*m]       = CPB + j;
      lens[2*m + 1]   = CPB - j;
    end
    lens[9] = CPB + (good ? 0 : extra_low);
    h = f;
    for (int c = 0; c < 10; c++) h += lens[c];
    if (good) begin
      exp_valid[p]    = 1'b1;
      exp_data_chg[p] = b;
      for (int c = f + 2; c < p; c++) exp_busy[c] = 1'b1;
    end else begin
      exp_ferr[p] = 1'b1;
      for (int c = f + 2; c <= h + 1; c++) exp_busy[c] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      bus.i_data = cells[c];
      repeat (lens[c]) @(negedge clock);
    end
    bus.i_data = 1'b1;
  endtask

  task automatic glitch(input int low_len);
    int f;
    f = edge_n + 1;
    for (int c = f + 2; c <= f + HALF + 2; c++) exp_busy[c] = 1'b1;
    bus.i_data = 1'b0;
    repeat (low_len) @(negedge clock);
    bus.i_data = 1'b1;
    repeat (HALF + 20) @(negedge clock);
  endtask

  initial begin
    int f, f2, r, kind;
    logic [7:0] b96;
    reset      = 1'b1;
    bus.i_data = 1'b1;
    repeat (3) @(negedge clock);
    check_output("reset_data",  int'(bus.o_data), 0);
    check_output("reset_valid", int'(bus.o_valid), 0);
    check_output("reset_ferr",  int'(bus.o_frame_err), 0);
    check_output("reset_busy",  int'(bus.o_busy), 0);
    chk_en = 1'b1;
    reset  = 1'b0;
    idle(10);

    $display("[TB] single frame 0xA5");
    clear_log();
    send_frame(8'hA5, 1'b1, 0, 0, 0, f);
    idle(20);
    check_output("a5_count",   vtimes.size(), 1);
    check_output("a5_data",    qget(vdatas, 0), 8'hA5);
    check_output("a5_latency", qget(vtimes, 0) - (f - 1), 830);
    check_output("a5_ferr",    ftimes.size(), 0);

    $display("[TB] back-to-back 0x00 0xFF 0x3C");
    clear_log();
    send_frame(8'h00, 1'b1, 0, 0, 0, f);
    send_frame(8'hFF, 1'b1, 0, 0, 0, f);
    send_frame(8'h3C, 1'b1, 0, 0, 0, f);
    idle(50);
    check_output("b2b_count", vtimes.size(), 3);
    check_output("b2b_d0",    qget(vdatas, 0), 8'h00);
    check_output("b2b_d1",    qget(vdatas, 1), 8'hFF);
    check_output("b2b_d2",    qget(vdatas, 2), 8'h3C);
    check_output("b2b_gap01", qget(vtimes, 1) - qget(vtimes, 0), 870);
    check_output("b2b_gap12", qget(vtimes, 2) - qget(vtimes, 1), 870);

    $display("[TB] 20-cycle glitch");
    clear_log();
    glitch(20);
    check_output("glitch_valid", vtimes.size(), 0);
    check_output("glitch_ferr",  ftimes.size(), 0);
    check_output("glitch_data",  int'(bus.o_data), 8'h3C);

    $display("[TB] bad stop 0x5A, break, then 0x11");
    clear_log();
    send_frame(8'h5A, 1'b0, 0, 0, 2000, f);
    idle(10);
    check_output("break_ferr_count", ftimes.size(), 1);
    check_output("break_ferr_lat",   qget(ftimes, 0) - (f - 1), 830);
    check_output("break_valid",      vtimes.size(), 0);
    check_output("break_data_kept",  int'(bus.o_data), 8'h3C);
    send_frame(8'h11, 1'b1, 0, 0, 0, f);
    idle(20);
    check_output("after_break_data", qget(vdatas, 0), 8'h11);

    $display("[TB] reset during bit 4 of 0x96, then 0x69");
    clear_log();
    b96 = 8'h96;
    f   = edge_n + 1;
    r   = f - 1 + 5 * CPB + 40;
    for (int c = f + 2; c <= r; c++) exp_busy[c] = 1'b1;
    exp_data_chg[r + 1] = 8'h00;
    bus.i_data = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      bus.i_data = b96[k];
      repeat (CPB) @(negedge clock);
    end
    bus.i_data = b96[4];
    repeat (40) @(negedge clock);
    reset      = 1'b1;
    bus.i_data = 1'b1;
    #1;
    check_output("rst_mid_data",  int'(bus.o_data), 0);
    check_output("rst_mid_valid", int'(bus.o_valid), 0);
    check_output("rst_mid_ferr",  int'(bus.o_frame_err), 0);
    check_output("rst_mid_busy",  int'(bus.o_busy), 0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    idle(20);
    send_frame(8'h69, 1'b1, 0, 0, 0, f2);
    idle(20);
    check_output("rst_pulse_count", vtimes.size(), 1);
    check_output("rst_then_data",   qget(vdatas, 0), 8'h69);

    $display("[TB] jittered 0xC3");
    clear_log();
    send_frame(8'hC3, 1'b1, 20, 20, 0, f);
    idle(20);
    check_output("jitter_data", qget(vdatas, 0), 8'hC3);

    $display("[TB] random traffic");
    for (int s = 0; s < 24; s++) begin
      kind = int'($urandom_range(9, 0));
      if (kind < 6) begin
        send_frame(8'($urandom_range(255, 0)), 1'b1, 0, 20, 0, f);
        if ($urandom_range(2, 0) != 0) idle(int'($urandom_range(150, 1)));
      end else if (kind < 8) begin
        glitch(int'($urandom_range(40, 1)));
      end else begin
        send_frame(8'($urandom_range(255, 0)), 1'b0, 0, 0, int'($urandom_range(300, 0)), f);
        idle(5 + int'($urandom_range(50, 0)));
      end
    end
    idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
